// File: rtl/mem_responder.sv
// Wait-state word/half/byte memory with little-endian lanes and error reporting.
// Optional MEM_RESPONDER_STATS_EN adds saturating rd_count/wr_count outputs.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic          a_we;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [1:0]    a_size;

  logic [31:0] ram [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   rsel;
  logic [31:0]   wlane;
  logic [3:0]    be;
  logic          acc_err;
  logic          fire;

  assign idx  = a_addr[AW+1:2];
  assign word = ram[idx];
  assign fire = (state == WAIT) && (cnt == '0);

  always_comb begin
    acc_err = 1'b0;
    unique case (1'b1)
      (a_size == 2'b11):                      acc_err = 1'b1;
      (a_size == 2'b01) && a_addr[0]:         acc_err = 1'b1;
      (a_size == 2'b00) && (a_addr[1:0] != 2'b00): acc_err = 1'b1;
      default:                                acc_err = 1'b0;
    endcase
    if ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS))
      acc_err = 1'b1;
  end

  always_comb begin
    rsel  = '0;
    wlane = '0;
    be    = '0;
    unique case (a_size)
      2'b00: begin
        rsel  = word;
        wlane = a_wdata;
        be    = 4'hF;
      end
      2'b01: begin
        rsel  = {16'h0, a_addr[1] ? word[31:16] : word[15:0]};
        wlane = {2{a_wdata[15:0]}};
        be    = a_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        unique case (a_addr[1:0])
          2'd0:    rsel = {24'h0, word[7:0]};
          2'd1:    rsel = {24'h0, word[15:8]};
          2'd2:    rsel = {24'h0, word[23:16]};
          default: rsel = {24'h0, word[31:24]};
        endcase
        wlane = {4{a_wdata[7:0]}};
        be    = 4'b0001 << a_addr[1:0];
      end
      default: begin
        rsel  = '0;
        wlane = '0;
        be    = '0;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req) state_n = WAIT;
      WAIT:    if (cnt == '0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      ready   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      a_we    <= 1'b0;
      a_addr  <= '0;
      a_wdata <= '0;
      a_size  <= '0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            a_we    <= we;
            a_addr  <= addr;
            a_wdata <= wdata;
            a_size  <= size;
            cnt     <= CW'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            ready <= 1'b1;
            err   <= acc_err;
            rdata <= (acc_err || a_we) ? '0 : rsel;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM is deliberately outside reset; aborts are covered by state clearing
  always_ff @(posedge clk) begin
    if (fire && a_we && !acc_err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[idx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESP && !err) begin
      if (a_we) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: shadow memory model, latency and
// sequencing checks, reset abort; stats checked when MEM_RESPONDER_STATS_EN.
module tb_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .size  (size),
    .ready (ready),
    .rdata (rdata),
    .err   (err)
`ifdef MEM_RESPONDER_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_resp = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  logic [32:0] sb [$];
  logic [31:0] mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s);
    logic        e;
    logic [31:0] r;
    logic [31:0] m;
    int          ix;
    int          sh;
    e  = (s == 2'b11) || (s == 2'b01 && a[0]) ||
         (s == 2'b00 && a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
    r  = '0;
    ix = int'(a[9:2]);
    sh = 8 * int'(a[1:0]);
    if (!e) begin
      m = mem[ix];
      if (w) begin
        case (s)
          2'b00:   m = d;
          2'b01:   m[sh +: 16] = d[15:0];
          default: m[sh +: 8] = d[7:0];
        endcase
        mem[ix] = m;
        exp_wr++;
      end else begin
        case (s)
          2'b00:   r = m;
          2'b01:   r = {16'h0, m[sh +: 16]};
          default: r = {24'h0, m[sh +: 8]};
        endcase
        exp_rd++;
      end
    end
    sb.push_back({e, r});
    n_push++;
  endtask

  always @(negedge clk) begin
    if (ready) begin
      n_resp++;
      if (sb.size() == 0) begin
        check("spurious_ready", {31'h0, ready}, 32'h0);
      end else begin
        logic [32:0] x;
        x = sb.pop_front();
        check("rdata", rdata, x[31:0]);
        check("err", {31'h0, err}, {31'h0, x[32]});
      end
    end
  end

  task automatic access(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s);
    int n;
    model(w, a, d, s);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; size = s;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d; size = ~s;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (ready) break;
    end
    check("latency", n, LAT + 1);
  endtask

  initial begin
    int t [3];
    int k;
    int cyc;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    access(1'b1, 32'h10, 32'hDEADBEEF, 2'b00);
    access(1'b0, 32'h10, 32'h0, 2'b00);
    access(1'b1, 32'h11, 32'h000000AA, 2'b10);
    access(1'b0, 32'h10, 32'h0, 2'b00);
    access(1'b0, 32'h12, 32'h0, 2'b01);
    access(1'b0, 32'h13, 32'h0, 2'b10);
    access(1'b1, 32'h16, 32'h00005A5A, 2'b01);
    access(1'b0, 32'h14, 32'h0, 2'b00);

    access(1'b1, 32'h13, 32'h11111111, 2'b00);
    access(1'b0, 32'h10, 32'h0, 2'b00);
    access(1'b1, 32'h11, 32'h22222222, 2'b01);
    access(1'b0, 32'h10, 32'h0, 2'b00);
    access(1'b1, 32'h10, 32'h33333333, 2'b11);
    access(1'b0, 32'h10, 32'h0, 2'b00);
    access(1'b1, 32'h400, 32'h44444444, 2'b00);
    access(1'b0, 32'h0, 32'h0, 2'b00);
    access(1'b0, 32'h3FC, 32'h0, 2'b00);

    // req held high: three back-to-back acceptances
    for (int i = 0; i < 3; i++) model(1'b0, 32'h10, 32'h0, 2'b00);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; size = 2'b00;
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ready) begin
        t[k] = cyc;
        k++;
      end
    end
    req = 1'b0;
    check("held_count", k, 3);
    if (k == 3) begin
      check("held_gap0", t[1] - t[0], LAT + 2);
      check("held_gap1", t[2] - t[1], LAT + 2);
    end

    // req pulsed during WAIT must not spawn a second response
    model(1'b0, 32'h14, 32'h0, 2'b00);
    @(negedge clk);
    req = 1'b1; addr = 32'h14; size = 2'b00; we = 1'b0;
    @(posedge clk);
    #1 req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (8) @(negedge clk);
    check("wait_req_resp", n_resp, n_push);

    // reset during WAIT aborts the write
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; size = 2'b00;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'h0, ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_resp", n_resp, n_push);
`ifdef MEM_RESPONDER_STATS_EN
    check("rd_after_rst", {16'h0, rd_count}, 32'h0);
    exp_rd = 0;
    exp_wr = 0;
`endif
    access(1'b0, 32'h20, 32'h0, 2'b00);
    access(1'b1, 32'h24, 32'hCAFEF00D, 2'b00);
    access(1'b0, 32'h24, 32'h0, 2'b00);
    access(1'b0, 32'h27, 32'h0, 2'b10);
    access(1'b1, 32'h25, 32'h0, 2'b01);
    access(1'b1, 32'h26, 32'h0000BEEF, 2'b01);
    access(1'b0, 32'h24, 32'h0, 2'b00);

    repeat (4) @(negedge clk);
    check("resp_total", n_resp, n_push);
    check("sb_empty", sb.size(), 0);
`ifdef MEM_RESPONDER_STATS_EN
    check("rd_count", {16'h0, rd_count}, exp_rd);
    check("wr_count", {16'h0, wr_count}, exp_wr);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
